display_scheduler: RTL and testbench

Controller in front of the 4-digit display multiplexer. Selects what is shown (current time, alarm preview, alarm edit, ringing) and produces per-digit blanking for blinking fields. Sequences the alarm-setting user flow, emitting increment strobes to the alarm register. Sits between the timekeeping/alarm blocks and the display multiplexer; all timing derives from a 1 kHz tick strobe.

---
 rtl/display_sched_pkg.sv | 40 ++++
 rtl/blink_timer.sv | 48 ++++
 rtl/display_scheduler.sv | 147 ++++++++++++++
 tb/tb_display_scheduler.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/display_sched_pkg.sv
// rtl/display_sched_pkg.sv - shared state codes, field codes and blank masks for display_scheduler
package display_sched_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_TIME     = 3'd0;
    localparam state_t ST_PREVIEW  = 3'd1;
    localparam state_t ST_EDIT_HR  = 3'd2;
    localparam state_t ST_EDIT_MIN = 3'd3;
    localparam state_t ST_RING     = 3'd4;

    localparam logic [1:0] FIELD_NONE  = 2'b00;
    localparam logic [1:0] FIELD_HOURS = 2'b01;
    localparam logic [1:0] FIELD_MINS  = 2'b10;

    localparam logic [3:0] BLANK_NONE  = 4'b0000;
    localparam logic [3:0] BLANK_HOURS = 4'b1100;
    localparam logic [3:0] BLANK_MINS  = 4'b0011;
    localparam logic [3:0] BLANK_ALL   = 4'b1111;

    // Digits that blink in a given state (applied only during the blank phase).
    function automatic logic [3:0] blank_mask(input state_t s);
        case (s)
            ST_EDIT_HR:  blank_mask = BLANK_HOURS;
            ST_EDIT_MIN: blank_mask = BLANK_MINS;
            ST_RING:     blank_mask = BLANK_ALL;
            default:     blank_mask = BLANK_NONE;
        endcase
    endfunction

    // Field currently under edit, as reported to the display side.
    function automatic logic [1:0] field_code(input state_t s);
        case (s)
            ST_EDIT_HR:  field_code = FIELD_HOURS;
            ST_EDIT_MIN: field_code = FIELD_MINS;
            default:     field_code = FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/blink_timer.sv
// rtl/blink_timer.sv - tick-driven blink phase generator with restart to visible
module blink_timer #(
    parameter int HALF_TICKS = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic restart_i,
    output logic phase_o
);

    localparam int W = $clog2(HALF_TICKS + 1);
    localparam logic [W-1:0] LAST = W'(HALF_TICKS - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         phase_q, phase_d;

    // Restart wins over a tick so a newly selected field is shown immediately.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (restart_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (tick_i) begin
            if (cnt_q >= LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    // Counter and phase registers; phase 0 = visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - display source selection, blink blanking and alarm-set sequencing
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter int BLINK_HALF_TICKS   = 500,
    parameter int PREVIEW_TICKS      = 3000,
    parameter int EDIT_TIMEOUT_TICKS = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_ms,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       alarm_ringing,
    input  logic [4:0] time_hours,
    input  logic [5:0] time_minutes,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    output logic [4:0] disp_hours,
    output logic [5:0] disp_minutes,
    output logic [3:0] digit_blank,
    output logic [1:0] edit_field,
    output logic       inc_hours,
    output logic       inc_minutes,
    output logic       alarm_stop
);

    // One counter serves both preview and edit timeouts; only one is live per state.
    localparam int CNT_MAX = (PREVIEW_TICKS > EDIT_TIMEOUT_TICKS) ? PREVIEW_TICKS : EDIT_TIMEOUT_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] PREVIEW_LAST = CW'(PREVIEW_TICKS - 1);
    localparam logic [CW-1:0] EDIT_LAST    = CW'(EDIT_TIMEOUT_TICKS - 1);
    localparam logic [CW-1:0] CNT_SAT      = CW'(CNT_MAX);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_clr;
    logic          state_change;
    logic          expire_preview, expire_edit;
    logic          blink_phase;
    logic          show_alarm;

    logic [4:0] disp_hours_q;
    logic [5:0] disp_minutes_q;
    logic [3:0] digit_blank_q;
    logic [1:0] edit_field_q;
    logic       inc_hours_q, inc_minutes_q, alarm_stop_q;

    // Expiry fires on the tick that brings the count up to the limit.
    assign expire_preview = tick_ms && (cnt_q >= PREVIEW_LAST);
    assign expire_edit    = tick_ms && (cnt_q >= EDIT_LAST);

    // Next-state logic: ringing overrides everything, btn_inc beats edit expiry.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        if (alarm_ringing) begin
            state_d = ST_RING;
        end else begin
            case (state_q)
                ST_TIME: begin
                    if (btn_mode) state_d = ST_PREVIEW;
                end
                ST_PREVIEW: begin
                    if (btn_mode)            state_d = ST_EDIT_HR;
                    else if (expire_preview) state_d = ST_TIME;
                end
                ST_EDIT_HR: begin
                    if (btn_mode)         state_d = ST_EDIT_MIN;
                    else if (btn_inc)     cnt_clr = 1'b1;
                    else if (expire_edit) state_d = ST_TIME;
                end
                ST_EDIT_MIN: begin
                    if (btn_mode)         state_d = ST_TIME;
                    else if (btn_inc)     cnt_clr = 1'b1;
                    else if (expire_edit) state_d = ST_TIME;
                end
                default: state_d = ST_TIME;
            endcase
        end
    end

    assign state_change = (state_d != state_q);

    // Timeout counter: cleared on any state change or increment, saturating on ticks.
    always_comb begin
        cnt_d = cnt_q;
        if (state_change || cnt_clr) begin
            cnt_d = '0;
        end else if (tick_ms && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_TIME;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    blink_timer #(
        .HALF_TICKS(BLINK_HALF_TICKS)
    ) u_blink (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_i   (tick_ms),
        .restart_i(state_change),
        .phase_o  (blink_phase)
    );

    assign show_alarm = (state_q == ST_PREVIEW) || (state_q == ST_EDIT_HR) || (state_q == ST_EDIT_MIN);

    // Registered output mux and strobes; strobes are suppressed when ringing takes over.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_hours_q   <= '0;
            disp_minutes_q <= '0;
            digit_blank_q  <= BLANK_NONE;
            edit_field_q   <= FIELD_NONE;
            inc_hours_q    <= 1'b0;
            inc_minutes_q  <= 1'b0;
            alarm_stop_q   <= 1'b0;
        end else begin
            disp_hours_q   <= show_alarm ? alarm_hours   : time_hours;
            disp_minutes_q <= show_alarm ? alarm_minutes : time_minutes;
            digit_blank_q  <= blink_phase ? blank_mask(state_q) : BLANK_NONE;
            edit_field_q   <= field_code(state_q);
            inc_hours_q    <= (state_q == ST_EDIT_HR)  && btn_inc  && !alarm_ringing;
            inc_minutes_q  <= (state_q == ST_EDIT_MIN) && btn_inc  && !alarm_ringing;
            alarm_stop_q   <= (state_q == ST_RING)     && btn_mode && alarm_ringing;
        end
    end

    assign disp_hours   = disp_hours_q;
    assign disp_minutes = disp_minutes_q;
    assign digit_blank  = digit_blank_q;
    assign edit_field   = edit_field_q;
    assign inc_hours    = inc_hours_q;
    assign inc_minutes  = inc_minutes_q;
    assign alarm_stop   = alarm_stop_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - directed self-checking bench for display_scheduler
module tb_display_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_ms = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       alarm_ringing = 1'b0;
    logic [4:0] time_hours = 5'd12;
    logic [5:0] time_minutes = 6'd34;
    logic [4:0] alarm_hours = 5'd7;
    logic [5:0] alarm_minutes = 6'd30;
    logic [4:0] disp_hours;
    logic [5:0] disp_minutes;
    logic [3:0] digit_blank;
    logic [1:0] edit_field;
    logic       inc_hours, inc_minutes, alarm_stop;

    int n_tests = 0;
    int n_fail  = 0;

    display_scheduler #(
        .BLINK_HALF_TICKS  (4),
        .PREVIEW_TICKS     (6),
        .EDIT_TIMEOUT_TICKS(10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_ms      (tick_ms),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .alarm_ringing(alarm_ringing),
        .time_hours   (time_hours),
        .time_minutes (time_minutes),
        .alarm_hours  (alarm_hours),
        .alarm_minutes(alarm_minutes),
        .disp_hours   (disp_hours),
        .disp_minutes (disp_minutes),
        .digit_blank  (digit_blank),
        .edit_field   (edit_field),
        .inc_hours    (inc_hours),
        .inc_minutes  (inc_minutes),
        .alarm_stop   (alarm_stop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_ms = 1'b1;
        cycle();
        tick_ms = 1'b0;
        cycle();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1;
        cycle();
        btn_mode = 1'b0;
    endtask

    task automatic pulse_inc();
        btn_inc = 1'b1;
        cycle();
        btn_inc = 1'b0;
    endtask

    initial begin
        // Reset values, then time tracking after release
        cycle();
        cycle();
        check("rst_disp_h", 32'(disp_hours), 32'd0);
        check("rst_disp_m", 32'(disp_minutes), 32'd0);
        check("rst_blank", 32'(digit_blank), 32'h0);
        check("rst_field", 32'(edit_field), 32'h0);
        rst_n = 1'b1;
        cycle();
        check("time_h", 32'(disp_hours), 32'd12);
        check("time_m", 32'(disp_minutes), 32'd34);
        time_minutes = 6'd35;
        cycle();
        check("time_track", 32'(disp_minutes), 32'd35);
        time_minutes = 6'd34;
        cycle();

        // Alarm preview and its timeout
        pulse_mode();
        cycle();
        check("prev_h", 32'(disp_hours), 32'd7);
        check("prev_m", 32'(disp_minutes), 32'd30);
        ticks(5);
        check("prev_hold", 32'(disp_hours), 32'd7);
        tick();
        check("prev_timeout", 32'(disp_hours), 32'd12);

        // Hours edit: increments and blink pattern
        pulse_mode();
        pulse_mode();
        cycle();
        check("ehr_field", 32'(edit_field), 32'h1);
        check("ehr_blank0", 32'(digit_blank), 32'h0);
        check("ehr_disp", 32'(disp_hours), 32'd7);
        for (int i = 0; i < 3; i++) begin
            pulse_inc();
            check("inc_h_hi", 32'(inc_hours), 32'd1);
            cycle();
            check("inc_h_lo", 32'(inc_hours), 32'd0);
        end
        ticks(3);
        check("ehr_blank3", 32'(digit_blank), 32'h0);
        tick();
        check("ehr_blank4", 32'(digit_blank), 32'hC);
        ticks(4);
        check("ehr_blank8", 32'(digit_blank), 32'h0);

        // Minutes edit: blink, btn_inc on expiry tick, timeout
        pulse_mode();
        cycle();
        check("emin_field", 32'(edit_field), 32'h2);
        check("emin_blank0", 32'(digit_blank), 32'h0);
        ticks(4);
        check("emin_blank4", 32'(digit_blank), 32'h3);
        ticks(5);
        tick_ms = 1'b1;
        btn_inc = 1'b1;
        cycle();
        check("inc_m_expiry", 32'(inc_minutes), 32'd1);
        tick_ms = 1'b0;
        btn_inc = 1'b0;
        cycle();
        check("inc_m_lo", 32'(inc_minutes), 32'd0);
        check("emin_stay", 32'(edit_field), 32'h2);
        ticks(9);
        check("emin_9ticks", 32'(edit_field), 32'h2);
        tick();
        check("emin_timeout", 32'(edit_field), 32'h0);
        check("emin_to_time", 32'(disp_hours), 32'd12);

        // Ringing overrides edit with a same-cycle increment
        pulse_mode();
        pulse_mode();
        cycle();
        check("ring_pre_field", 32'(edit_field), 32'h1);
        alarm_ringing = 1'b1;
        btn_inc = 1'b1;
        cycle();
        check("ring_no_inc", 32'(inc_hours), 32'd0);
        btn_inc = 1'b0;
        cycle();
        check("ring_field", 32'(edit_field), 32'h0);
        check("ring_blank0", 32'(digit_blank), 32'h0);
        check("ring_disp", 32'(disp_hours), 32'd12);
        ticks(4);
        check("ring_blank4", 32'(digit_blank), 32'hF);
        ticks(4);
        check("ring_blank8", 32'(digit_blank), 32'h0);
        pulse_mode();
        check("stop_hi", 32'(alarm_stop), 32'd1);
        cycle();
        check("stop_lo", 32'(alarm_stop), 32'd0);
        alarm_ringing = 1'b0;
        cycle();
        cycle();
        pulse_mode();
        check("time_no_stop", 32'(alarm_stop), 32'd0);
        cycle();
        check("ring_exit_prev", 32'(disp_hours), 32'd7);

        // Reset during minutes edit
        pulse_mode();
        pulse_mode();
        cycle();
        check("rst2_pre_field", 32'(edit_field), 32'h2);
        rst_n = 1'b0;
        btn_inc = 1'b1;
        cycle();
        check("rst2_no_inc", 32'(inc_minutes), 32'd0);
        check("rst2_field", 32'(edit_field), 32'h0);
        check("rst2_disp_h", 32'(disp_hours), 32'd0);
        check("rst2_disp_m", 32'(disp_minutes), 32'd0);
        check("rst2_blank", 32'(digit_blank), 32'h0);
        rst_n = 1'b1;
        btn_inc = 1'b0;
        cycle();
        check("rst2_time", 32'(disp_hours), 32'd12);
        check("rst2_field_after", 32'(edit_field), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
